// File: rtl/verificador_nonce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | verificador_nonce                                                        |
// | Buffers (entrada, nonce) submissions, hashes {entrada, nonce} through an  |
// | external engine, checks the result against target and keeps totals.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module verificador_nonce #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [95:0]  in_entrada,
  input  logic [31:0]  in_nonce,
  input  logic [7:0]   target,
  output logic         hash_start,
  output logic [127:0] hash_bloque,
  input  logic         hash_done,
  input  logic [23:0]  hash_H,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_nonce,
  output logic [23:0]  res_bounty,
  output logic         res_ok,
  output logic         res_timeout,
  output logic [15:0]  cnt_ok,
  output logic [15:0]  cnt_bad
);

  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_tmr_w = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_ptr_w:0]   c_depth    = (c_ptr_w + 1)'(FIFO_DEPTH);
  // Last WAIT cycle: the increment from this value would reach TIMEOUT_CYC-1.
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT_CYC - 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_CMP   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [127:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w:0]     r_count;
  logic [c_tmr_w-1:0]   r_timer;
  logic [7:0]           r_tgt;
  logic                 w_push;
  logic                 w_pop;

  assign in_ready = reset_L && (r_count < c_depth);
  assign w_push   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_entrada, in_nonce};
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    hash_start   = 1'b0;
    res_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        hash_start   = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (hash_done)                  w_state_next = S_CMP;
        else if (r_timer == c_tmr_last) w_state_next = S_OUT;
      end
      S_CMP:   w_state_next = S_OUT;
      S_OUT: begin
        res_valid = 1'b1;
        if (res_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      hash_bloque <= '0;
      r_tgt       <= '0;
      r_timer     <= '0;
      res_nonce   <= '0;
      res_bounty  <= '0;
      res_ok      <= 1'b0;
      res_timeout <= 1'b0;
      cnt_ok      <= '0;
      cnt_bad     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            hash_bloque <= r_mem[r_rd_ptr];
            res_nonce   <= r_mem[r_rd_ptr][31:0];
            r_tgt       <= target;
          end
        end
        S_START: begin
          r_timer     <= '0;
          res_timeout <= 1'b0;
          res_ok      <= 1'b0;
          res_bounty  <= '0;
        end
        S_WAIT: begin
          if (hash_done) begin
            res_bounty <= hash_H;
          end else if (r_timer == c_tmr_last) begin
            res_timeout <= 1'b1;
            res_bounty  <= '0;
            res_ok      <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_CMP: res_ok <= (res_bounty[23:16] < r_tgt) && (res_bounty[15:8] < r_tgt);
        S_OUT: begin
          if (res_ready) begin
            if (res_ok) begin
              if (cnt_ok != 16'hFFFF) cnt_ok <= cnt_ok + 1'b1;
            end else begin
              if (cnt_bad != 16'hFFFF) cnt_bad <= cnt_bad + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_verificador_nonce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_verificador_nonce                                                     |
// | Directed vector table plus hand sequences for verificador_nonce.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_verificador_nonce;

  logic         clk = 1'b0;
  logic         reset_L;
  logic         in_valid;
  logic         in_ready;
  logic [95:0]  in_entrada;
  logic [31:0]  in_nonce;
  logic [7:0]   target;
  logic         hash_start;
  logic [127:0] hash_bloque;
  logic         hash_done;
  logic [23:0]  hash_H;
  logic         res_valid;
  logic         res_ready;
  logic [31:0]  res_nonce;
  logic [23:0]  res_bounty;
  logic         res_ok;
  logic         res_timeout;
  logic [15:0]  cnt_ok;
  logic [15:0]  cnt_bad;

  logic         man_done = 1'b0;
  logic [23:0]  man_H = '0;
  logic         eng_done = 1'b0;
  logic [23:0]  eng_H = '0;
  logic         auto_eng = 1'b0;

  int           checks = 0;
  int           errors = 0;
  logic [15:0]  exp_ok_cnt = '0;
  logic [15:0]  exp_bad_cnt = '0;

  assign hash_done = man_done | eng_done;
  assign hash_H    = eng_done ? eng_H : man_H;

  always #5 clk = ~clk;

  verificador_nonce #(.FIFO_DEPTH(4), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .reset_L(reset_L),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_entrada(in_entrada), .in_nonce(in_nonce), .target(target),
    .hash_start(hash_start), .hash_bloque(hash_bloque),
    .hash_done(hash_done), .hash_H(hash_H),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_nonce(res_nonce), .res_bounty(res_bounty),
    .res_ok(res_ok), .res_timeout(res_timeout),
    .cnt_ok(cnt_ok), .cnt_bad(cnt_bad)
  );

  typedef struct {
    logic [95:0] entrada;
    logic [31:0] nonce;
    logic [7:0]  tgt;
    logic [23:0] h;
    int          dly;
    logic        exp_ok;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [95:0] e, input logic [31:0] n);
    int k = 0;
    in_valid   = 1'b1;
    in_entrada = e;
    in_nonce   = n;
    while (!in_ready && k < 200) begin
      tick();
      k++;
    end
    chk("push_ready", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!res_valid && k < 200) begin
      tick();
      k++;
    end
    chk(name, 128'(res_valid), 128'(1));
  endtask

  task automatic bump_expected(input logic ok);
    if (ok) exp_ok_cnt  = (exp_ok_cnt  == 16'hFFFF) ? 16'hFFFF : exp_ok_cnt + 16'd1;
    else    exp_bad_cnt = (exp_bad_cnt == 16'hFFFF) ? 16'hFFFF : exp_bad_cnt + 16'd1;
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_start"},   128'(hash_start),  128'(0));
    chk({name, "_bloque"},  hash_bloque,       128'(0));
    chk({name, "_valid"},   128'(res_valid),   128'(0));
    chk({name, "_nonce"},   128'(res_nonce),   128'(0));
    chk({name, "_bounty"},  128'(res_bounty),  128'(0));
    chk({name, "_ok"},      128'(res_ok),      128'(0));
    chk({name, "_timeout"}, 128'(res_timeout), 128'(0));
    chk({name, "_cnt_ok"},  128'(cnt_ok),      128'(0));
    chk({name, "_cnt_bad"}, 128'(cnt_bad),     128'(0));
    chk({name, "_ready"},   128'(in_ready),    128'(0));
  endtask

  // One full verification from an empty, idle block, engine answering by hand.
  task automatic run_vec(input vec_t v);
    target = v.tgt;
    push(v.entrada, v.nonce);
    chk("start_early", 128'(hash_start), 128'(0));
    tick();
    chk("start_latency", 128'(hash_start), 128'(1));
    chk("bloque", hash_bloque, {v.entrada, v.nonce});
    tick();
    repeat (v.dly) tick();
    man_done = 1'b1;
    man_H    = v.h;
    tick();
    man_done = 1'b0;
    man_H    = 24'hFFFFFF;
    chk("valid_in_cmp", 128'(res_valid), 128'(0));
    tick();
    chk("valid_latency", 128'(res_valid), 128'(1));
    chk("res_nonce", 128'(res_nonce), 128'(v.nonce));
    chk("res_bounty", 128'(res_bounty), 128'(v.h));
    chk("res_ok", 128'(res_ok), 128'(v.exp_ok));
    chk("res_timeout", 128'(res_timeout), 128'(0));
    bump_expected(v.exp_ok);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("valid_after_ack", 128'(res_valid), 128'(0));
    chk("cnt_ok", 128'(cnt_ok), 128'(exp_ok_cnt));
    chk("cnt_bad", 128'(cnt_bad), 128'(exp_bad_cnt));
  endtask

  // Engine that answers each start after a few cycles with H = {01, 02, nonce[7:0]}.
  always begin
    @(posedge clk);
    #1;
    if (auto_eng && hash_start) begin
      tick();
      tick();
      tick();
      eng_done = 1'b1;
      eng_H    = {8'h01, 8'h02, hash_bloque[7:0]};
      tick();
      eng_done = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t4_nonce [5];
    logic        seen_start;
    logic        seen_valid;
    logic        stable_bad;

    vecs[0] = '{96'h0, 32'h0000_0005, 8'h10, 24'h0F0FAA, 2, 1'b1};
    vecs[1] = '{96'hDEAD_BEEF_0000_1111_2222_3333, 32'hCAFE_0001, 8'h10, 24'h100000, 0, 1'b0};
    vecs[2] = '{96'h1, 32'h1234_5678, 8'h10, 24'h0F1000, 1, 1'b0};
    vecs[3] = '{96'h2, 32'h0000_0000, 8'h00, 24'h000000, 3, 1'b0};
    vecs[4] = '{96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 8'hFF, 24'hFEFEFF, 0, 1'b1};
    vecs[5] = '{96'h3, 32'h8000_0000, 8'hFF, 24'hFFFE00, 4, 1'b0};
    vecs[6] = '{96'h0123_4567_89AB_CDEF_0011_2233, 32'h0BAD_F00D, 8'h80, 24'h7F7F00, 5, 1'b1};

    reset_L    = 1'b0;
    in_valid   = 1'b0;
    in_entrada = '0;
    in_nonce   = '0;
    target     = '0;
    res_ready  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    reset_L = 1'b1;
    tick();
    chk("rst_release_ready", 128'(in_ready), 128'(1));
    chk("rst_release_valid", 128'(res_valid), 128'(0));

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Engine never answers: timeout 64 cycles after start, late done ignored.
    target = 8'h10;
    push(96'h55, 32'hABCD_0003);
    tick();
    chk("t3_start", 128'(hash_start), 128'(1));
    seen_valid = 1'b0;
    for (int k = 1; k < 64; k++) begin
      tick();
      seen_valid |= res_valid;
    end
    chk("t3_no_early_result", 128'(seen_valid), 128'(0));
    tick();
    chk("t3_valid_at_64", 128'(res_valid), 128'(1));
    chk("t3_timeout", 128'(res_timeout), 128'(1));
    chk("t3_bounty", 128'(res_bounty), 128'(0));
    chk("t3_ok", 128'(res_ok), 128'(0));
    chk("t3_nonce", 128'(res_nonce), 128'(32'hABCD_0003));
    man_done = 1'b1;
    man_H    = 24'h000000;
    tick();
    man_done = 1'b0;
    chk("t3_late_valid", 128'(res_valid), 128'(1));
    chk("t3_late_timeout", 128'(res_timeout), 128'(1));
    chk("t3_late_bounty", 128'(res_bounty), 128'(0));
    bump_expected(1'b0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t3_cnt_bad", 128'(cnt_bad), 128'(exp_bad_cnt));
    chk("t3_cnt_ok", 128'(cnt_ok), 128'(exp_ok_cnt));

    // Burst of five with consumer stalled: 4 buffered + 1 in flight.
    auto_eng = 1'b1;
    target   = 8'h10;
    for (int j = 0; j < 5; j++) t4_nonce[j] = 32'h7000_0010 + 32'(j * 17);
    in_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      in_entrada = 96'(j + 100);
      in_nonce   = t4_nonce[j];
      chk("t4_ready_during_burst", 128'(in_ready), 128'(1));
      tick();
    end
    in_valid = 1'b0;
    chk("t4_full", 128'(in_ready), 128'(0));
    for (int j = 0; j < 5; j++) begin
      wait_valid("t4_wait_valid");
      chk("t4_nonce", 128'(res_nonce), 128'(t4_nonce[j]));
      chk("t4_bloque_nonce", 128'(hash_bloque[31:0]), 128'(t4_nonce[j]));
      chk("t4_bounty", 128'(res_bounty), 128'({8'h01, 8'h02, t4_nonce[j][7:0]}));
      chk("t4_ok", 128'(res_ok), 128'(1));
      stable_bad = 1'b0;
      repeat (3) begin
        tick();
        if (!res_valid || res_nonce !== t4_nonce[j] || hash_bloque[31:0] !== t4_nonce[j])
          stable_bad = 1'b1;
      end
      chk("t4_stable", 128'(stable_bad), 128'(0));
      bump_expected(1'b1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
    chk("t4_cnt_ok", 128'(cnt_ok), 128'(exp_ok_cnt));
    chk("t4_ready_after", 128'(in_ready), 128'(1));
    auto_eng = 1'b0;
    repeat (8) tick();

    // Reset during WAIT with two entries queued.
    in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_entrada = 96'(j + 200);
      in_nonce   = 32'h5000_0000 + 32'(j);
      tick();
    end
    in_valid = 1'b0;
    chk("t5_in_wait", 128'(hash_start), 128'(0));
    tick();
    tick();
    reset_L = 1'b0;
    #1;
    check_all_zero("t5_rst");
    tick();
    reset_L = 1'b1;
    tick();
    chk("t5_ready", 128'(in_ready), 128'(1));
    man_done = 1'b1;
    man_H    = 24'h000000;
    tick();
    man_done   = 1'b0;
    seen_start = 1'b0;
    seen_valid = 1'b0;
    repeat (100) begin
      tick();
      seen_start |= hash_start;
      seen_valid |= res_valid;
    end
    chk("t5_no_start", 128'(seen_start), 128'(0));
    chk("t5_no_result", 128'(seen_valid), 128'(0));
    chk("t5_cnt_ok", 128'(cnt_ok), 128'(0));
    chk("t5_cnt_bad", 128'(cnt_bad), 128'(0));
    exp_ok_cnt  = '0;
    exp_bad_cnt = '0;
    run_vec(vecs[0]);

    // Saturation of the accepted counter.
    force dut.cnt_ok = 16'hFFFE;
    tick();
    release dut.cnt_ok;
    exp_ok_cnt = 16'hFFFE;
    run_vec(vecs[6]);
    chk("t6_reach_max", 128'(cnt_ok), 128'(16'hFFFF));
    run_vec(vecs[4]);
    chk("t6_saturated", 128'(cnt_ok), 128'(16'hFFFF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
